// File: rtl/mempool_uart_sink.sv
// AXI4 write sink for the UART window: W byte lane 0 becomes a character in a
// first-word-fall-through FIFO, writes get ordered OKAY responses, reads SLVERR.

package mempool_uart_sink_pkg;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [5:0] id;
        logic [1:0] resp;
        logic [0:0] user;
    } axi_b_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [0:0]  user;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        axi_b_t b;
        logic   r_valid;
        axi_r_t r;
    } axi_resp_t;

endpackage

module mempool_uart_sink #(
    parameter type         axi_req_t     = mempool_uart_sink_pkg::axi_req_t,
    parameter type         axi_resp_t    = mempool_uart_sink_pkg::axi_resp_t,
    parameter int unsigned CharFifoDepth = 16,
    parameter int unsigned IdFifoDepth   = 4
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  axi_req_i,
    output axi_resp_t axi_resp_o,
    output logic [7:0] char_o,
    output logic      char_valid_o,
    input  logic      char_ready_i,
    output logic      busy_o
);

    localparam int unsigned CPW     = $clog2(CharFifoDepth) + 1;
    localparam int unsigned IPW     = $clog2(IdFifoDepth) + 1;
    localparam int unsigned IdWidth = $bits(axi_req_i.aw.id);
    localparam int unsigned LenW    = $bits(axi_req_i.ar.len);

    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    logic                 active;
    logic [CPW-1:0]       char_wr_ptr, char_rd_ptr;
    logic [7:0]           char_mem [CharFifoDepth];
    logic [IPW-1:0]       id_wr_ptr, id_rd_ptr;
    logic [IdWidth-1:0]   id_mem [IdFifoDepth];
    logic [IPW-1:0]       wlast_cnt;
    r_state_t             state, state_next;
    logic [IdWidth-1:0]   r_id, r_id_next;
    logic [LenW-1:0]      r_cnt, r_cnt_next;

    logic char_empty, char_full, id_empty, id_full, wlast_sat;
    logic aw_ready, w_ready, b_valid, ar_ready, r_valid;
    logic aw_hs, w_hs, b_hs, char_pop, char_push;
    logic unused_req;

    assign unused_req = ^axi_req_i;

    assign char_empty = (char_wr_ptr == char_rd_ptr);
    assign char_full  = (char_wr_ptr[CPW-1] != char_rd_ptr[CPW-1]) &&
                        (char_wr_ptr[CPW-2:0] == char_rd_ptr[CPW-2:0]);
    assign id_empty   = (id_wr_ptr == id_rd_ptr);
    assign id_full    = (id_wr_ptr[IPW-1] != id_rd_ptr[IPW-1]) &&
                        (id_wr_ptr[IPW-2:0] == id_rd_ptr[IPW-2:0]);
    assign wlast_sat  = (wlast_cnt == IPW'(IdFifoDepth));

    // Readies derive only from registered state; a pop this cycle is not seen.
    assign aw_ready = active && !id_full;
    assign w_ready  = active && !char_full && !wlast_sat;
    assign b_valid  = !id_empty && (wlast_cnt != '0);

    assign aw_hs     = axi_req_i.aw_valid && aw_ready;
    assign w_hs      = axi_req_i.w_valid && w_ready;
    assign b_hs      = b_valid && axi_req_i.b_ready;
    assign char_push = w_hs && axi_req_i.w.strb[0];
    assign char_pop  = char_valid_o && char_ready_i;

    assign char_valid_o = !char_empty;
    assign char_o       = char_empty ? '0 : char_mem[char_rd_ptr[CPW-2:0]];
    assign busy_o       = !char_empty || !id_empty || (wlast_cnt != '0) || (state == R_RESP);

    // Hold all readies low until the first clock after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) active <= 1'b0;
        else         active <= 1'b1;
    end

    // Character FIFO storage and pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            char_wr_ptr <= '0;
            char_rd_ptr <= '0;
            for (int unsigned i = 0; i < CharFifoDepth; i++) char_mem[i] <= '0;
        end else begin
            if (char_push) begin
                char_mem[char_wr_ptr[CPW-2:0]] <= axi_req_i.w.data[7:0];
                char_wr_ptr <= char_wr_ptr + CPW'(1);
            end
            if (char_pop) char_rd_ptr <= char_rd_ptr + CPW'(1);
        end
    end

    // Outstanding AW ID FIFO, popped by B handshakes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_wr_ptr <= '0;
            id_rd_ptr <= '0;
            for (int unsigned i = 0; i < IdFifoDepth; i++) id_mem[i] <= '0;
        end else begin
            if (aw_hs) begin
                id_mem[id_wr_ptr[IPW-2:0]] <= axi_req_i.aw.id;
                id_wr_ptr <= id_wr_ptr + IPW'(1);
            end
            if (b_hs) id_rd_ptr <= id_rd_ptr + IPW'(1);
        end
    end

    // Count of completed W bursts still waiting for their B.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wlast_cnt <= '0;
        end else begin
            case ({w_hs && axi_req_i.w.last, b_hs})
                2'b10:   wlast_cnt <= wlast_cnt + IPW'(1);
                2'b01:   wlast_cnt <= wlast_cnt - IPW'(1);
                default: wlast_cnt <= wlast_cnt;
            endcase
        end
    end

    // Read FSM state register with latched ID and remaining-beat counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= R_IDLE;
            r_id  <= '0;
            r_cnt <= '0;
        end else begin
            state <= state_next;
            r_id  <= r_id_next;
            r_cnt <= r_cnt_next;
        end
    end

    // Read FSM next state: accept one AR, then return len+1 SLVERR beats.
    always_comb begin
        state_next = state;
        r_id_next  = r_id;
        r_cnt_next = r_cnt;
        ar_ready   = 1'b0;
        r_valid    = 1'b0;
        case (state)
            R_IDLE: begin
                ar_ready = active;
                if (axi_req_i.ar_valid && active) begin
                    r_id_next  = axi_req_i.ar.id;
                    r_cnt_next = axi_req_i.ar.len;
                    state_next = R_RESP;
                end
            end
            R_RESP: begin
                r_valid = 1'b1;
                if (axi_req_i.r_ready) begin
                    if (r_cnt == '0) state_next = R_IDLE;
                    else             r_cnt_next = r_cnt - LenW'(1);
                end
            end
            default: state_next = R_IDLE;
        endcase
    end

    // Assemble the response struct.
    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = aw_ready;
        axi_resp_o.w_ready  = w_ready;
        axi_resp_o.b_valid  = b_valid;
        axi_resp_o.b.id     = id_mem[id_rd_ptr[IPW-2:0]];
        axi_resp_o.b.resp   = 2'b00;
        axi_resp_o.ar_ready = ar_ready;
        axi_resp_o.r_valid  = r_valid;
        axi_resp_o.r.id     = r_id;
        axi_resp_o.r.resp   = 2'b10;
        axi_resp_o.r.last   = (state == R_RESP) && (r_cnt == '0);
    end

endmodule
